// File: rtl/tx_serializer_pkg.sv
// Shared types and defaults for the framed serial transmitter.
//   state_t       : transmitter FSM states
//   DATA_W_DEF    : default data bits per frame
//   STOP_BITS_DEF : default number of stop bits
package tx_serializer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StStart,
    StData,
    StStop
  } state_t;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned STOP_BITS_DEF = 1;

endpackage

// File: rtl/tx_serializer.sv
// Parallel-to-serial framed transmitter. A word accepted over valid/ready is sent as one start
// bit (0), DATA_W data bits and STOP_BITS stop bits (1); every bit lasts one shift_en period.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active high
//   shift_en   : one-cycle bit-rate strobe from the clock divider
//   tx_data    : word to send, sampled on the handshake
//   tx_valid   : upstream has a word
//   tx_ready   : block can accept a word (registered, high only when idle)
//   serial_out : serial line, idles high (registered)
//   busy       : frame in progress (registered)
//   frame_done : one-cycle pulse when the last stop bit completes (registered)
module tx_serializer
  import tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned STOP_BITS = STOP_BITS_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  // The counter also counts stop bits, so it must hold STOP_BITS even for DATA_W=1.
  localparam int unsigned CntMax = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntData = CntW'(DATA_W);
  localparam logic [CntW-1:0] CntStop = CntW'(STOP_BITS);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              serial_q, serial_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Bit presented at the output end of the shift register, and the register after shifting
  // that bit out.
  logic              out_bit;
  logic [DATA_W-1:0] shreg_shifted;

  always_comb begin
    if (MSB_FIRST) begin
      out_bit       = shreg_q[DATA_W-1];
      shreg_shifted = shreg_q << 1;
    end else begin
      out_bit       = shreg_q[0];
      shreg_shifted = shreg_q >> 1;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        serial_d = 1'b1;
        // shift_en is deliberately ignored here, even on the capture cycle.
        if (tx_valid && ready_q) begin
          shreg_d = tx_data;
          state_d = StWaitStart;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      // Waiting for a strobe so the start bit spans a full bit period.
      StWaitStart: begin
        if (shift_en) begin
          serial_d = 1'b0;
          state_d  = StStart;
        end
      end

      StStart: begin
        if (shift_en) begin
          serial_d = out_bit;
          shreg_d  = shreg_shifted;
          cnt_d    = CntOne;
          state_d  = StData;
        end
      end

      // cnt_q is the number of data bits already placed on the line.
      StData: begin
        if (shift_en) begin
          if (cnt_q == CntData) begin
            serial_d = 1'b1;
            cnt_d    = CntOne;
            state_d  = StStop;
          end else begin
            serial_d = out_bit;
            shreg_d  = shreg_shifted;
            cnt_d    = cnt_q + CntOne;
          end
        end
      end

      StStop: begin
        if (shift_en) begin
          if (cnt_q == CntStop) begin
            state_d = StIdle;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      default: begin
        state_d  = StIdle;
        serial_d = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_ready   = ready_q;
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
